switch_conditioner: RTL and testbench

- Input-conditioning stage between the raw board switches/buttons and the VGA game logic (`newvga` sw1..sw4 inputs).
- Per channel: 2-flop synchronise, debounce with a saturating stability counter, then emit a clean level plus single-cycle rise/fall pulses.
- Replaces the per-switch debouncer instances with one parameterised N-channel block that also provides edge strobes.

---
 rtl/switch_conditioner_pkg.sv | 18 +
 rtl/debounce_channel.sv | 139 +++++++++++++
 rtl/switch_conditioner.sv | 40 ++++
 tb/tb_switch_conditioner.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_conditioner_pkg.sv
// rtl/switch_conditioner_pkg.sv - shared constants and FSM state type for the switch conditioner
package switch_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_REPEAT_DELAY    = 50000000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10000000;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    // Larger of two widths, used to size the shared repeat timer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one-bit synchroniser, debounce FSM and edge/repeat strobes (optional SWITCH_CONDITIONER_HOLD_REPEAT_EN)
module debounce_channel
    import switch_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;

`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    localparam int               REP_W     = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_rep_nxt;
`endif

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, stability counter and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Debounce decision: any bounce back to the accepted level restarts the count.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            ST_STABLE: begin
                if (r_sync2 != r_level) begin
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_PENDING;
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_PENDING: begin
                if (r_sync2 == r_level) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_level_nxt = r_sync2;
                    w_rise_nxt  = r_sync2;
                    w_fall_nxt  = ~r_sync2;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_STABLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STABLE;
            end
        endcase
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
        // Repeat timer counts down while the accepted level stays high.
        w_rep_nxt = '0;
        if (w_level_nxt) begin
            if (!r_level) begin
                w_rep_nxt = REP_FIRST;
            end else if (r_rep == '0) begin
                w_rise_nxt = 1'b1;
                w_rep_nxt  = REP_NEXT;
            end else begin
                w_rep_nxt = r_rep - REP_W'(1);
            end
        end
`endif
    end

`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    // Auto-repeat timer register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rep <= '0;
        end else begin
            r_rep <= w_rep_nxt;
        end
    end
`endif

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - N-channel switch debouncer with edge strobes (optional SWITCH_CONDITIONER_HOLD_REPEAT_EN)
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw_raw,
    output logic [N_CH-1:0] sw_level,
    output logic [N_CH-1:0] sw_rise,
    output logic [N_CH-1:0] sw_fall
);

    // One fully independent conditioner per input bit.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
            ,
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
`endif
        ) u_ch (
            .i_clk   (clk),
            .i_reset (reset),
            .i_raw   (sw_raw[i]),
            .o_level (sw_level[i]),
            .o_rise  (sw_rise[i]),
            .o_fall  (sw_fall[i])
        );
    end

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - self-checking bench for switch_conditioner
module tb_switch_conditioner;

    localparam int N = 4;
    localparam int D = 8;
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    localparam int RD = 20;
    localparam int RP = 5;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_raw;
    logic [N-1:0] sw_level;
    logic [N-1:0] sw_rise;
    logic [N-1:0] sw_fall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    switch_conditioner #(
        .N_CH           (N),
        .DEBOUNCE_CYCLES(D)
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
        ,
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
`endif
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_raw   (sw_raw),
        .sw_level (sw_level),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall)
    );

    // Reference model: raw is seen two edges late; a level is accepted once it has
    // differed from the accepted level for D consecutive edges.
    logic [N-1:0] q[$];
    logic [N-1:0] m_level, m_rise, m_fall;
    int           m_run[N];
    int           m_since[N];

    task automatic model_reset();
        q.delete();
        q.push_back('0);
        q.push_back('0);
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i]   = 0;
            m_since[i] = 0;
        end
    endtask

    task automatic tick(input logic [N-1:0] raw);
        logic [N-1:0] s;
        sw_raw = raw;
        @(posedge clk);
        q.push_back(raw);
        s = q.pop_front();
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] !== m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == D) begin
                m_level[i] = s[i];
                m_run[i]   = 0;
                if (s[i]) m_rise[i] = 1'b1;
                else m_fall[i] = 1'b1;
            end
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
            if (!m_level[i] || m_rise[i]) begin
                m_since[i] = 0;
            end else begin
                m_since[i]++;
                if (m_since[i] == RD || (m_since[i] > RD && (m_since[i] - RD) % RP == 0))
                    m_rise[i] = 1'b1;
            end
`endif
        end
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = '1;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (sw_level !== '0 || sw_rise !== '0 || sw_fall !== '0) begin
                n_fail++;
                $display("FAIL reset_hold level=%b rise=%b fall=%b expected all 0", sw_level, sw_rise, sw_fall);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1111);
            n_tests++;
            if (sw_level !== ((k >= 10) ? 4'b1111 : 4'b0000) ||
                sw_rise  !== ((k == 10) ? 4'b1111 : 4'b0000) || sw_fall !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_release edge=%0d level=%b rise=%b fall=%b", k, sw_level, sw_rise, sw_fall);
            end
        end
    endtask

    task automatic test_clean_press();
        for (int k = 1; k <= 14; k++) begin
            tick(4'b0000);
            n_tests++;
            if (sw_fall !== ((k == 10) ? 4'b1111 : 4'b0000) || sw_rise !== sw_rise & m_rise) begin
                n_fail++;
                $display("FAIL release_all edge=%0d fall=%b expected %b", k, sw_fall, (k == 10) ? 4'b1111 : 4'b0000);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0001);
            n_tests++;
            if (sw_level !== {3'b000, k >= 10} || sw_rise !== {3'b000, k == 10} || sw_fall !== 4'b0000) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d level=%b rise=%b fall=%b", k, sw_level, sw_rise, sw_fall);
            end
        end
    endtask

    task automatic test_bounce();
        logic [N-1:0] raw;
        for (int j = 1; j <= 18; j++) begin
            raw = 4'b0001;
            raw[1] = (j <= 3 || j >= 7);
            tick(raw);
            n_tests++;
            if (sw_level[1] !== (j >= 16) || sw_rise[1] !== (j == 16) || sw_fall[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce step=%0d level1=%b rise1=%b fall1=%b", j, sw_level[1], sw_rise[1], sw_fall[1]);
            end
        end
    endtask

    task automatic test_glitch();
        for (int j = 1; j <= 20; j++) begin
            tick((j <= 7) ? 4'b0111 : 4'b0011);
            n_tests++;
            if (sw_level[2] !== 1'b0 || sw_rise[2] !== 1'b0 || sw_fall[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch step=%0d level2=%b rise2=%b fall2=%b", j, sw_level[2], sw_rise[2], sw_fall[2]);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        for (int j = 1; j <= 10; j++) tick(4'b1011);
        n_tests++;
        if (sw_level[3] !== 1'b1 || sw_rise[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_accept level3=%b rise3=%b expected 1 1", sw_level[3], sw_rise[3]);
        end
        for (int j = 1; j <= 4; j++) tick(4'b0011);
        reset = 1'b1;
        #1;
        n_tests++;
        if (sw_level !== 4'b0000 || sw_rise !== 4'b0000 || sw_fall !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset level=%b rise=%b fall=%b expected all 0", sw_level, sw_rise, sw_fall);
        end
        model_reset();
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (sw_fall !== 4'b0000 || sw_level !== 4'b0000) begin
                n_fail++;
                $display("FAIL mid_reset_hold level=%b fall=%b expected 0 0", sw_level, sw_fall);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
    task automatic test_hold_repeat();
        for (int k = 1; k <= 14; k++) tick(4'b0000);
        for (int k = 1; k <= 42; k++) begin
            tick(4'b0001);
            n_tests++;
            if (sw_rise[0] !== (k == 10 || k == 30 || k == 35 || k == 40)) begin
                n_fail++;
                $display("FAIL hold_repeat step=%0d rise0=%b", k, sw_rise[0]);
            end
        end
        for (int k = 1; k <= 14; k++) begin
            tick(4'b0000);
            n_tests++;
            if (sw_fall[0] !== (k == 10) || sw_rise[0] !== ((k < 10) ? m_rise[0] : 1'b0)) begin
                n_fail++;
                $display("FAIL hold_release step=%0d rise0=%b fall0=%b", k, sw_rise[0], sw_fall[0]);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic [N-1:0] raw;
        int           hold[N];
        raw = sw_raw;
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(14, 1);
        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    raw[i]  = ~raw[i];
                    hold[i] = ($urandom_range(3, 0) == 0) ? $urandom_range(40, 9) : $urandom_range(12, 1);
                end
            end
            tick(raw);
            n_tests++;
            if (sw_level !== m_level || sw_rise !== m_rise || sw_fall !== m_fall || (sw_rise & sw_fall) !== '0) begin
                n_fail++;
                $display("FAIL random cyc=%0d level=%b/%b rise=%b/%b fall=%b/%b (dut/model)",
                         c, sw_level, m_level, sw_rise, m_rise, sw_fall, m_fall);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        sw_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_reset_mid_count();
`ifdef SWITCH_CONDITIONER_HOLD_REPEAT_EN
        test_hold_repeat();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
